// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: client-side burst ports plus the single SDRAM controller port.
// slave = arbiter view, master = clients and controller (environment) view.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4
);
  localparam int OFS_W = $clog2(BURST_LEN);

  // Handshake: a client raises p_req[k] with p_address/p_wren stable and keeps them
  // until its last beat; each beat is one p_ready[k] strobe echoing mem_ready, with
  // p_offset naming the beat. mem_req stays high for a whole burst and the controller
  // answers with exactly BURST_LEN mem_ready strobes.
  logic [NUM_PORTS-1:0]            p_req;
  logic [NUM_PORTS-1:0]            p_wren;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] p_address;
  logic [NUM_PORTS*DATA_WIDTH-1:0] p_to_mem;
  logic [NUM_PORTS-1:0]            p_ready;
  logic [OFS_W-1:0]                p_offset;
  logic [DATA_WIDTH-1:0]           from_mem;

  logic                            mem_req;
  logic                            mem_wren;
  logic [ADDR_WIDTH-1:0]           mem_address;
  logic [DATA_WIDTH-1:0]           mem_to_mem;
  logic                            mem_ready;
  logic [OFS_W-1:0]                mem_offset;
  logic [DATA_WIDTH-1:0]           mem_data;

  modport slave (
    input  p_req, p_wren, p_address, p_to_mem, mem_ready, mem_offset, mem_data,
    output p_ready, p_offset, from_mem, mem_req, mem_wren, mem_address, mem_to_mem
  );

  modport master (
    output p_req, p_wren, p_address, p_to_mem, mem_ready, mem_offset, mem_data,
    input  p_ready, p_offset, from_mem, mem_req, mem_wren, mem_address, mem_to_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: N-port atomic-burst arbiter in front of one SDRAM controller port.
// Define MEMARB_AGING_EN to add loss-count aging to fixed-priority mode (RR_MODE=0).
module mem_port_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int RR_MODE    = 1,
  parameter int AGE_LIMIT  = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus,
  output logic [1:0]        state_dbg
);
  localparam int OFS_W = $clog2(BURST_LEN);
  localparam int PW    = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                 state;
  logic [PW-1:0]          grant;
  logic [PW-1:0]          rr_ptr;
  logic [OFS_W-1:0]       beat_cnt;
  logic                   mem_req_q;
  logic                   mem_wren_q;
  logic [ADDR_WIDTH-1:0]  mem_address_q;

  logic [ADDR_WIDTH-1:0]  addr_a  [NUM_PORTS];
  logic [DATA_WIDTH-1:0]  wdata_a [NUM_PORTS];
  logic                   any_req;
  logic [PW-1:0]          fp_idx;
  logic [PW-1:0]          rr_idx;
  logic [PW-1:0]          sel_idx;
  logic [PW-1:0]          win_idx;
  logic [PW-1:0]          win_next;
  logic [NUM_PORTS-1:0]   p_ready_c;
  logic [DATA_WIDTH-1:0]  to_mem_c;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      addr_a[i]  = bus.p_address[i*ADDR_WIDTH +: ADDR_WIDTH];
      wdata_a[i] = bus.p_to_mem[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign any_req = |bus.p_req;

  // Descending scan so the lowest requesting index is the last one written.
  always_comb begin
    fp_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (bus.p_req[i]) fp_idx = PW'(i);
    end
  end

  always_comb begin
    logic          hit;
    logic [PW-1:0] cand;
    rr_idx = '0;
    hit    = 1'b0;
    cand   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NUM_PORTS);
      if (!hit && bus.p_req[cand]) begin
        rr_idx = cand;
        hit    = 1'b1;
      end
    end
  end

`ifdef MEMARB_AGING_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);

  logic [AW-1:0] loss_cnt [NUM_PORTS];
  logic          aged_hit;
  logic [PW-1:0] aged_idx;

  always_comb begin
    aged_hit = 1'b0;
    aged_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (bus.p_req[i] && (loss_cnt[i] >= AW'(AGE_LIMIT))) begin
        aged_hit = 1'b1;
        aged_idx = PW'(i);
      end
    end
  end

  assign sel_idx = aged_hit ? aged_idx : fp_idx;

  // A loss is a requesting port passed over at an IDLE arbitration; saturates at AGE_LIMIT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PORTS; i++) loss_cnt[i] <= '0;
    end else if (state == IDLE && any_req) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (PW'(i) == win_idx) begin
          loss_cnt[i] <= '0;
        end else if (bus.p_req[i] && (loss_cnt[i] < AW'(AGE_LIMIT))) begin
          loss_cnt[i] <= loss_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign sel_idx = fp_idx;
`endif

  assign win_idx  = (RR_MODE != 0) ? rr_idx : sel_idx;
  assign win_next = (win_idx == PW'(NUM_PORTS - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      grant         <= '0;
      rr_ptr        <= '0;
      beat_cnt      <= '0;
      mem_req_q     <= 1'b0;
      mem_wren_q    <= 1'b0;
      mem_address_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant         <= win_idx;
            rr_ptr        <= win_next;
            mem_address_q <= addr_a[win_idx];
            mem_wren_q    <= bus.p_wren[win_idx];
            mem_req_q     <= 1'b1;
            state         <= BURST;
          end
        end
        BURST: begin
          if (bus.mem_ready) begin
            if (beat_cnt == OFS_W'(BURST_LEN - 1)) begin
              beat_cnt  <= '0;
              mem_req_q <= 1'b0;
              state     <= DONE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        // Spacer cycle: the served client sees its last beat and drops p_req here.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    p_ready_c = '0;
    to_mem_c  = '0;
    if (state == BURST) begin
      p_ready_c[grant] = bus.mem_ready;
      to_mem_c         = wdata_a[grant];
    end
  end

  assign bus.p_ready     = p_ready_c;
  assign bus.p_offset    = bus.mem_offset;
  assign bus.from_mem    = bus.mem_data;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_wren    = mem_wren_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_to_mem  = to_mem_c;
  assign state_dbg       = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench driving a round-robin and a fixed-priority
// arbiter with identical stimulus and checking each against hand-computed grants.
module tb_mem_port_arbiter;
  localparam int NP = 4;
  localparam int AW = 24;
  localparam int DW = 16;
  localparam int BL = 4;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BURST = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP-1:0]    p_req;
  logic [NP-1:0]    p_wren;
  logic [NP*AW-1:0] p_address;
  logic [NP*DW-1:0] p_to_mem;
  logic             mem_ready;
  logic [1:0]       mem_offset;
  logic [DW-1:0]    mem_data;
  logic [1:0]       state_rr;
  logic [1:0]       state_fp;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_rr_q[$];
  logic [2:0] exp_fp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) bus_rr ();
  mem_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL)) bus_fp ();

  assign bus_rr.p_req      = p_req;
  assign bus_rr.p_wren     = p_wren;
  assign bus_rr.p_address  = p_address;
  assign bus_rr.p_to_mem   = p_to_mem;
  assign bus_rr.mem_ready  = mem_ready;
  assign bus_rr.mem_offset = mem_offset;
  assign bus_rr.mem_data   = mem_data;
  assign bus_fp.p_req      = p_req;
  assign bus_fp.p_wren     = p_wren;
  assign bus_fp.p_address  = p_address;
  assign bus_fp.p_to_mem   = p_to_mem;
  assign bus_fp.mem_ready  = mem_ready;
  assign bus_fp.mem_offset = mem_offset;
  assign bus_fp.mem_data   = mem_data;

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL),
                     .RR_MODE(1), .AGE_LIMIT(8)) dut_rr (
    .clk(clk), .reset(reset), .bus(bus_rr), .state_dbg(state_rr));

  mem_port_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BL),
                     .RR_MODE(0), .AGE_LIMIT(8)) dut_fp (
    .clk(clk), .reset(reset), .bus(bus_fp), .state_dbg(state_fp));

  // ---------------- model helpers ----------------
  function automatic logic [AW-1:0] addr_of(input logic [2:0] k);
    return 24'h001000 + {11'd0, k, 8'h00};
  endfunction

  function automatic logic [DW-1:0] wdata_of(input int k, input int b);
    return 16'hA3A0 + 16'(k * 256) + 16'(b);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wdata(input int b);
    for (int k = 0; k < NP; k++) p_to_mem[k*DW +: DW] = wdata_of(k, b);
  endtask

  task automatic do_reset(input string tag);
    reset      = 1'b0;
    mem_ready  = 1'b0;
    mem_offset = 2'd0;
    mem_data   = '0;
    tick();
    tick();
    @(negedge clk);
    check({tag, " rst_req_rr"},  bus_rr.mem_req, 0);
    check({tag, " rst_req_fp"},  bus_fp.mem_req, 0);
    check({tag, " rst_addr_rr"}, bus_rr.mem_address, 0);
    check({tag, " rst_wren_rr"}, bus_rr.mem_wren, 0);
    check({tag, " rst_st_rr"},   state_rr, S_IDLE);
    check({tag, " rst_rdy_rr"},  bus_rr.p_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Entered at the first BURST cycle; leaves at the DONE-cycle negedge.
  task automatic run_burst(input string tag, input bit spur);
    logic [2:0]    w_rr, w_fp;
    logic [NP-1:0] oh_rr, oh_fp;
    w_rr  = exp_rr_q.pop_front();
    w_fp  = exp_fp_q.pop_front();
    oh_rr = 4'b0001 << w_rr;
    oh_fp = 4'b0001 << w_fp;
    for (int b = 0; b < BL; b++) begin
      mem_ready  = 1'b1;
      mem_offset = 2'(b);
      mem_data   = 16'h1230 + 16'(b);
      set_wdata(b);
      @(negedge clk);
      if (b == 0) begin
        check({tag, " addr_rr"}, bus_rr.mem_address, addr_of(w_rr));
        check({tag, " addr_fp"}, bus_fp.mem_address, addr_of(w_fp));
        check({tag, " wren_rr"}, bus_rr.mem_wren, p_wren[w_rr]);
        check({tag, " wren_fp"}, bus_fp.mem_wren, p_wren[w_fp]);
        check({tag, " st_rr"},   state_rr, S_BURST);
      end
      check({tag, " rdy_rr"},  bus_rr.p_ready, oh_rr);
      check({tag, " rdy_fp"},  bus_fp.p_ready, oh_fp);
      check({tag, " ofs_rr"},  bus_rr.p_offset, b);
      check({tag, " rd_rr"},   bus_rr.from_mem, 16'h1230 + 16'(b));
      check({tag, " rd_fp"},   bus_fp.from_mem, 16'h1230 + 16'(b));
      check({tag, " wd_rr"},   bus_rr.mem_to_mem, wdata_of(int'(w_rr), b));
      check({tag, " wd_fp"},   bus_fp.mem_to_mem, wdata_of(int'(w_fp), b));
      check({tag, " req_rr"},  bus_rr.mem_req, 1);
      check({tag, " req_fp"},  bus_fp.mem_req, 1);
      tick();
      if (b == 1) begin
        mem_ready = 1'b0;
        @(negedge clk);
        check({tag, " stall_rdy_rr"}, bus_rr.p_ready, 0);
        check({tag, " stall_req_rr"}, bus_rr.mem_req, 1);
        tick();
      end
    end
    mem_ready = spur;
    mem_data  = 16'hDEAD;
    @(negedge clk);
    check({tag, " done_st_rr"},  state_rr, S_DONE);
    check({tag, " done_st_fp"},  state_fp, S_DONE);
    check({tag, " done_req_rr"}, bus_rr.mem_req, 0);
    check({tag, " done_req_fp"}, bus_fp.mem_req, 0);
    check({tag, " done_rdy_rr"}, bus_rr.p_ready, 0);
    check({tag, " done_rdy_fp"}, bus_fp.p_ready, 0);
    check({tag, " done_wd_rr"},  bus_rr.mem_to_mem, 0);
  endtask

  // DONE -> IDLE with a spurious controller strobe; leaves just after the IDLE edge.
  task automatic idle_cycle(input string tag);
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    check({tag, " idle_st_rr"},  state_rr, S_IDLE);
    check({tag, " idle_st_fp"},  state_fp, S_IDLE);
    check({tag, " idle_req_rr"}, bus_rr.mem_req, 0);
    check({tag, " idle_req_fp"}, bus_fp.mem_req, 0);
    check({tag, " idle_rdy_rr"}, bus_rr.p_ready, 0);
    check({tag, " idle_rdy_fp"}, bus_fp.p_ready, 0);
    tick();
    mem_ready = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    p_req    = '0;
    p_wren   = '0;
    p_to_mem = '0;
    for (int k = 0; k < NP; k++) p_address[k*AW +: AW] = addr_of(3'(k));

    // Single read burst from port 0, including one-cycle grant latency.
    p_req = 4'b0001;
    do_reset("t1");
    @(negedge clk);
    check("t1 latency_req_rr", bus_rr.mem_req, 0);
    tick();
    exp_rr_q.push_back(3'd0);
    exp_fp_q.push_back(3'd0);
    run_burst("t1", 1'b1);
    p_req = 4'b0000;
    idle_cycle("t1");
    @(negedge clk);
    check("t1 spur_st_rr", state_rr, S_IDLE);
    check("t1 spur_st_fp", state_fp, S_IDLE);

    // All ports requesting: RR cycles 0,1,2,3,0; fixed priority sticks to 0.
    p_req = 4'b1111;
    do_reset("t2");
    tick();
    exp_rr_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    exp_fp_q = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    run_burst("t2", 1'b1);
    for (int n = 1; n < 5; n++) begin
      idle_cycle("t2");
      run_burst("t2", 1'b0);
    end
    p_req = 4'b0000;
    idle_cycle("t2");

    // Ports 1 and 3 requesting: RR alternates; fixed priority starves 3 unless aged.
    p_req = 4'b1010;
    do_reset("t3");
    tick();
    for (int n = 0; n < 9; n++) begin
      exp_rr_q.push_back((n % 2 == 0) ? 3'd1 : 3'd3);
`ifdef MEMARB_AGING_EN
      exp_fp_q.push_back((n == 8) ? 3'd3 : 3'd1);
`else
      exp_fp_q.push_back(3'd1);
`endif
    end
    run_burst("t3", 1'b0);
    for (int n = 1; n < 9; n++) begin
      idle_cycle("t3");
      run_burst("t3", 1'b0);
    end
    p_req = 4'b0000;
    idle_cycle("t3");

    // Write burst from port 2: mem_to_mem walks 0xA5A0..0xA5A3.
    p_req  = 4'b0100;
    p_wren = 4'b0100;
    do_reset("t4");
    tick();
    exp_rr_q.push_back(3'd2);
    exp_fp_q.push_back(3'd2);
    run_burst("t4", 1'b0);
    p_req  = 4'b0000;
    p_wren = 4'b0000;
    idle_cycle("t4");

    // Reset during beat 2 aborts; later grants start from pointer 0 with a fresh counter.
    p_req = 4'b0001;
    do_reset("t5");
    tick();
    for (int b = 0; b < 2; b++) begin
      mem_ready  = 1'b1;
      mem_offset = 2'(b);
      tick();
    end
    mem_offset = 2'd2;
    reset      = 1'b0;
    @(negedge clk);
    check("t5 beat2_rdy_rr", bus_rr.p_ready, 4'b0001);
    tick();
    @(negedge clk);
    check("t5 abort_req_rr", bus_rr.mem_req, 0);
    check("t5 abort_req_fp", bus_fp.mem_req, 0);
    check("t5 abort_rdy_rr", bus_rr.p_ready, 0);
    check("t5 abort_rdy_fp", bus_fp.p_ready, 0);
    check("t5 abort_st_rr",  state_rr, S_IDLE);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    mem_ready = 1'b0;
    p_req     = 4'b0010;
    tick();
    exp_rr_q.push_back(3'd1);
    exp_fp_q.push_back(3'd1);
    run_burst("t5", 1'b0);
    p_req = 4'b0000;
    idle_cycle("t5");
    p_req = 4'b1011;
    tick();
    exp_rr_q.push_back(3'd3);
    exp_fp_q.push_back(3'd0);
    run_burst("t5b", 1'b0);
    p_req = 4'b0000;
    idle_cycle("t5b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
